// File: rtl/multicycle_control.sv
// Sequencing controller for the multi-cycle RISC-V core: steps the shared
// datapath one state per clock, runs the memory handshake and counts retirements.
module multicycle_control #(
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [6:0]               Opcode,
  input  logic [2:0]               Funct3,
  input  logic [2:0]               ALUCompareResult,
  input  logic                     MemReady,
  output logic                     MemReq,
  output logic                     MemWrite,
  output logic                     AdrSrc,
  output logic                     IRWrite,
  output logic                     PCWrite,
  output logic                     RegWrite,
  output logic [1:0]               ResultSrc,
  output logic [1:0]               ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [1:0]               ALUOp,
  output logic                     Retire,
  output logic                     Halted,
  output logic [INSTRET_WIDTH-1:0] InstRet
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    BOOT, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JAL, JALR, JALRPC, UPPER, TRAP
  } stateT;

  stateT state;
  stateT nextState;
  logic  branchTaken;
  logic  branchLegal;
  logic [INSTRET_WIDTH-1:0] instRetQ;

  // State register; reset drops straight back to BOOT, abandoning any access.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= BOOT;
    end else begin
      state <= nextState;
    end
  end

  // Branch condition from funct3; 010/011 are not branch encodings.
  always_comb begin
    branchTaken = 1'b0;
    branchLegal = 1'b1;
    case (Funct3)
      3'b000:  branchTaken =  ALUCompareResult[0];
      3'b001:  branchTaken = !ALUCompareResult[0];
      3'b100:  branchTaken =  ALUCompareResult[1];
      3'b101:  branchTaken = !ALUCompareResult[1];
      3'b110:  branchTaken =  ALUCompareResult[2];
      3'b111:  branchTaken = !ALUCompareResult[2];
      default: branchLegal = 1'b0;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      BOOT:     nextState = FETCH;
      FETCH:    if (MemReady) nextState = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: nextState = MEMADR;
          OP_RTYPE:          nextState = EXECR;
          OP_ITYPE:          nextState = EXECI;
          OP_BRANCH:         nextState = BRANCH;
          OP_JAL:            nextState = JAL;
          OP_JALR:           nextState = JALR;
          OP_LUI, OP_AUIPC:  nextState = UPPER;
          default:           nextState = TRAP;
        endcase
      end
      MEMADR:   nextState = (Opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (MemReady) nextState = MEMWB;
      MEMWB:    nextState = FETCH;
      MEMWRITE: if (MemReady) nextState = FETCH;
      EXECR:    nextState = ALUWB;
      EXECI:    nextState = ALUWB;
      ALUWB:    nextState = FETCH;
      BRANCH:   nextState = branchLegal ? FETCH : TRAP;
      JAL:      nextState = ALUWB;
      JALR:     nextState = JALRPC;
      JALRPC:   nextState = ALUWB;
      UPPER:    nextState = ALUWB;
      TRAP:     nextState = TRAP;
      default:  nextState = BOOT;
    endcase
  end

  // Outputs are decoded from state; only the fetch strobes, store retire and
  // branch PC write also look at this cycle's handshake / compare inputs.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    Retire    = 1'b0;
    Halted    = 1'b0;
    case (state)
      FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
      end
      MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        Retire   = MemReady;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = branchLegal && branchTaken;
        Retire  = branchLegal;
      end
      JAL, JALRPC: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      UPPER: begin
        ALUSrcA = (Opcode == OP_LUI) ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
      end
      TRAP:    Halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      instRetQ <= '0;
    end else if (Retire) begin
      instRetQ <= instRetQ + 1'b1;
    end
  end

  assign InstRet = instRetQ;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for a multi-cycle build of the RISC-V core. It steps the shared datapath (PC, instruction/data memory port, register file, Extend, ALU) through per-instruction states, one state per clock. It drives all datapath strobes and mux selects, handles a ready-based memory handshake, detects illegal instructions and keeps a retired-instruction counter. Opcode and funct3 come from the registered instruction (IR).

## Interface
- INSTRET_WIDTH, 32, width of the retired-instruction counter
- CLK  in  1  clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-low reset
- Opcode  in  7  IR[6:0]
- Funct3  in  3  IR[14:12]
- ALUCompareResult  in  3  [0] equal, [1] signed less-than, [2] unsigned less-than (Src1 vs Src2)
- MemReady  in  1  memory accepted/completed current access this cycle
- MemReq  out  1  memory access request
- MemWrite  out  1  store strobe, valid only with MemReq
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALU result (direct)
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
- ALUSrcB  out  2  00 RD2, 01 ExtImm, 10 constant 4
- ALUOp  out  2  00 add, 01 branch compare, 10 decode from funct fields
- Retire  out  1  one-cycle pulse in the final cycle of an instruction
- Halted  out  1  sticky; set in TRAP
- InstRet  out  INSTRET_WIDTH  retired-instruction count

## Operation
- States: BOOT, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRPC, UPPER, TRAP.
- In every state, outputs not listed below are 0.
- BOOT: all outputs 0. Next state is FETCH.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite equal MemReady.
  - Stays in FETCH until MemReady, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, so ALUOut holds OldPC+imm. Next state by Opcode:
  - 0000011 and 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 and 0010111 → UPPER
  - anything else → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: MemReq=1, AdrSrc=1. Waits for MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1. Next is FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. Waits for MemReady; in the MemReady cycle Retire=1 and next is FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next is ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1. Next is FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=taken, Retire=1. Next is FETCH.
  - taken by Funct3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - Funct3 010 or 011 → TRAP instead; no PCWrite, no Retire.
- JAL: PCWrite=1, ResultSrc=00 (target from DECODE), ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next is ALUWB, which writes the link value.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is JALRPC.
- JALRPC: PCWrite=1, ResultSrc=00, ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next is ALUWB.
- UPPER: ALUSrcB=01, ALUOp=00. ALUSrcA=11 for LUI (0110111), 01 for AUIPC. Next is ALUWB.
- TRAP: Halted=1, all strobes 0. Stays in TRAP until Reset.
- InstRet increments by 1 on each clock edge where Retire=1, and wraps modulo 2^INSTRET_WIDTH.

## Timing
- Reset asserted (low): state=BOOT, InstRet=0, Halted=0, all outputs 0 immediately (asynchronous).
- Reset deassertion: one BOOT cycle, then FETCH.
- Reset asserted mid-instruction or mid-wait: the access is abandoned and no write strobe is issued after the reset edge.
- All outputs are Moore (decoded from state), except these, which are combinational on MemReady/ALUCompareResult/Funct3 within the cycle:
  - FETCH IRWrite and PCWrite
  - MEMWRITE Retire
  - BRANCH PCWrite
- Handshake: MemReq, AdrSrc and MemWrite stay stable from assertion until the cycle MemReady=1. MemReady outside FETCH, MEMREAD and MEMWRITE is ignored.
- Latency with zero-wait memory:
  - R/I-ALU, store, JAL, LUI/AUIPC: 4 cycles
  - load, JALR: 5 cycles
  - branch: 3 cycles
  - each memory wait cycle adds 1.
- Retire falls in the last cycle of the instruction, and the next FETCH follows in the next cycle.

## Test plan
- Reset low for 3 cycles, then high with MemReady=1: all outputs 0 during reset, 1 BOOT cycle, FETCH with MemReq=1 and IRWrite=PCWrite=1, DECODE next.
- Opcode 0110011, zero-wait: 4 cycles, RegWrite only in ALUWB, Retire once, InstRet 0→1.
- Opcode 0000011 with MemReady low for 2 cycles in MEMREAD: AdrSrc=1 and MemReq held 3 cycles, MEMWB has ResultSrc=01, 7 cycles total.
- Branch with Funct3=001: ALUCompareResult=3'b001 gives PCWrite=0; 3'b000 gives PCWrite=1. Funct3=010 → TRAP with Halted=1 and InstRet unchanged.
- Opcode 1100111: sequence DECODE→JALR→JALRPC→ALUWB, PCWrite only in JALRPC, RegWrite only in ALUWB.
- Opcode 0000000 → TRAP with Halted=1 held for 20 cycles; Reset low mid-TRAP clears Halted and returns to BOOT. Preloading InstRet to all-ones (via force) then retiring once wraps it to 0.
